// File: rtl/master_tx_ltssm.sv
`default_nettype none
// ============================================================================
// Module      : master_tx_ltssm
// Description : TX-side LTSSM sequencer; drives ordered-set generators per
//               substate, waits for RX completion, sends post-RX sets.
// Revision    : 1.0 - initial release
// ============================================================================
module master_tx_ltssm #(
  parameter int POLL_ACTIVE_MIN = 1024,
  parameter int POST_RX_COUNT   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] substate,
  input  logic       osSent,
  input  logic       rxFinish,
  input  logic [3:0] rxExitTo,
  input  logic       timeOut,
  output logic [1:0] osType,
  output logic       sendEnable,
  output logic       electricalIdle,
  output logic [5:0] setTimer,
  output logic       enableTimer,
  output logic       resetTimer,
  output logic       finish,
  output logic [3:0] exitTo
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_SENDING = 3'd1;
  localparam logic [2:0] c_ST_POST    = 3'd2;
  localparam logic [2:0] c_ST_DONE    = 3'd3;
  localparam logic [2:0] c_ST_FAIL    = 3'd4;

  localparam logic [1:0] c_OS_NONE = 2'd0;
  localparam logic [1:0] c_OS_TS1  = 2'd1;
  localparam logic [1:0] c_OS_TS2  = 2'd2;
  localparam logic [1:0] c_OS_IDL  = 2'd3;

  localparam logic [10:0] c_POLL_MIN = 11'(POLL_ACTIVE_MIN);
  localparam logic [4:0]  c_POST_N   = 5'(POST_RX_COUNT);
  localparam logic [10:0] c_SENT_MAX = 11'h7FF;

  logic [2:0]  r_state;
  logic [2:0]  w_nextState;

  logic [3:0]  r_lastSubstate;
  logic [10:0] r_sentCount;
  logic [4:0]  r_postCount;
  logic        r_rxSeen;
  logic [3:0]  r_rxExit;
  logic [10:0] r_minSend;
  logic [4:0]  r_postN;

  logic [1:0]  r_osType;
  logic        r_sendEnable;
  logic        r_electricalIdle;
  logic [5:0]  r_setTimer;
  logic        r_enableTimer;
  logic        r_resetTimer;
  logic        r_finish;
  logic [3:0]  r_exitTo;

  logic [1:0]  w_nxtOsType;
  logic        w_nxtSendEnable;
  logic        w_nxtElectricalIdle;
  logic [5:0]  w_nxtSetTimer;
  logic        w_nxtEnableTimer;
  logic        w_nxtResetTimer;
  logic        w_nxtFinish;
  logic [3:0]  w_nxtExitTo;

  logic [1:0]  w_cfgOsType;
  logic [10:0] w_cfgMinSend;
  logic [4:0]  w_cfgPostN;
  logic [5:0]  w_cfgTimer;
  logic        w_cfgActive;

  logic        w_subChange;
  logic [4:0]  w_postInc;
  logic        w_sendDone;

  assign w_subChange = (substate != r_lastSubstate);
  assign w_postInc   = r_postCount + 5'd1;
  assign w_sendDone  = r_rxSeen && (r_sentCount >= r_minSend);

  // Per-substate generator setup; substates outside 2..9 keep TX quiet.
  always_comb begin
    w_cfgOsType  = c_OS_NONE;
    w_cfgMinSend = '0;
    w_cfgPostN   = '0;
    w_cfgTimer   = '0;
    w_cfgActive  = 1'b1;
    case (substate)
      4'd2: begin
        w_cfgOsType  = c_OS_TS1;
        w_cfgMinSend = c_POLL_MIN;
        w_cfgTimer   = 6'd24;
      end
      4'd3: begin
        w_cfgOsType = c_OS_TS2;
        w_cfgPostN  = c_POST_N;
        w_cfgTimer  = 6'd48;
      end
      4'd4, 4'd5, 4'd7: begin
        w_cfgOsType = c_OS_TS1;
        w_cfgTimer  = 6'd24;
      end
      4'd6: begin
        w_cfgOsType = c_OS_TS1;
        w_cfgTimer  = 6'd2;
      end
      4'd8: begin
        w_cfgOsType = c_OS_TS2;
        w_cfgPostN  = c_POST_N;
        w_cfgTimer  = 6'd24;
      end
      4'd9: begin
        w_cfgOsType = c_OS_IDL;
        w_cfgPostN  = c_POST_N;
        w_cfgTimer  = 6'd24;
      end
      default: w_cfgActive = 1'b0;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= c_ST_IDLE;
      r_osType         <= c_OS_NONE;
      r_sendEnable     <= 1'b0;
      r_electricalIdle <= 1'b1;
      r_setTimer       <= '0;
      r_enableTimer    <= 1'b0;
      r_resetTimer     <= 1'b0;
      r_finish         <= 1'b0;
      r_exitTo         <= '0;
    end else begin
      r_state          <= w_nextState;
      r_osType         <= w_nxtOsType;
      r_sendEnable     <= w_nxtSendEnable;
      r_electricalIdle <= w_nxtElectricalIdle;
      r_setTimer       <= w_nxtSetTimer;
      r_enableTimer    <= w_nxtEnableTimer;
      r_resetTimer     <= w_nxtResetTimer;
      r_finish         <= w_nxtFinish;
      r_exitTo         <= w_nxtExitTo;
    end
  end

  // Next state: timeOut outranks a substate change, which outranks RX progress.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_subChange && w_cfgActive) w_nextState = c_ST_SENDING;
      end
      c_ST_SENDING: begin
        if (timeOut)                             w_nextState = c_ST_FAIL;
        else if (w_subChange)                    w_nextState = c_ST_IDLE;
        else if (r_rxSeen && (r_rxExit == 4'd0)) w_nextState = c_ST_FAIL;
        else if (w_sendDone)                     w_nextState = (r_postN != 5'd0) ? c_ST_POST : c_ST_DONE;
      end
      c_ST_POST: begin
        if (timeOut)                             w_nextState = c_ST_FAIL;
        else if (w_subChange)                    w_nextState = c_ST_IDLE;
        else if (osSent && (w_postInc == r_postN)) w_nextState = c_ST_DONE;
      end
      c_ST_DONE, c_ST_FAIL: w_nextState = c_ST_IDLE;
      default:              w_nextState = c_ST_IDLE;
    endcase
  end

  // Output values presented on the edge that enters w_nextState
  always_comb begin
    w_nxtOsType         = r_osType;
    w_nxtSendEnable     = r_sendEnable;
    w_nxtElectricalIdle = r_electricalIdle;
    w_nxtSetTimer       = r_setTimer;
    w_nxtEnableTimer    = r_enableTimer;
    w_nxtResetTimer     = 1'b0;
    w_nxtFinish         = 1'b0;
    w_nxtExitTo         = r_exitTo;
    case (r_state)
      c_ST_IDLE: begin
        if (w_subChange) begin
          if (w_cfgActive) begin
            w_nxtOsType         = w_cfgOsType;
            w_nxtSendEnable     = 1'b1;
            w_nxtElectricalIdle = 1'b0;
            w_nxtSetTimer       = w_cfgTimer;
            w_nxtResetTimer     = 1'b1;
            w_nxtEnableTimer    = 1'b1;
          end else begin
            w_nxtOsType         = c_OS_NONE;
            w_nxtSendEnable     = 1'b0;
            w_nxtElectricalIdle = 1'b1;
          end
        end
      end
      c_ST_SENDING, c_ST_POST: begin
        case (w_nextState)
          c_ST_DONE: begin
            w_nxtFinish      = 1'b1;
            w_nxtExitTo      = r_rxExit;
            w_nxtOsType      = c_OS_NONE;
            w_nxtSendEnable  = 1'b0;
            w_nxtEnableTimer = 1'b0;
          end
          c_ST_FAIL: begin
            w_nxtFinish         = 1'b1;
            w_nxtExitTo         = 4'd0;
            w_nxtOsType         = c_OS_NONE;
            w_nxtSendEnable     = 1'b0;
            w_nxtElectricalIdle = 1'b1;
            w_nxtEnableTimer    = 1'b0;
          end
          c_ST_IDLE: begin
            w_nxtOsType      = c_OS_NONE;
            w_nxtSendEnable  = 1'b0;
            w_nxtEnableTimer = 1'b0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Counters, RX latch and per-substate configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastSubstate <= 4'd15;
      r_sentCount    <= '0;
      r_postCount    <= '0;
      r_rxSeen       <= 1'b0;
      r_rxExit       <= '0;
      r_minSend      <= '0;
      r_postN        <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_subChange) begin
            r_lastSubstate <= substate;
            if (w_cfgActive) begin
              r_minSend   <= w_cfgMinSend;
              r_postN     <= w_cfgPostN;
              r_sentCount <= '0;
              r_postCount <= '0;
              r_rxSeen    <= 1'b0;
            end
          end
        end
        c_ST_SENDING: begin
          if (osSent && (r_sentCount != c_SENT_MAX)) r_sentCount <= r_sentCount + 11'd1;
          if (rxFinish) begin
            r_rxSeen <= 1'b1;
            r_rxExit <= rxExitTo;
          end
        end
        c_ST_POST: begin
          if (osSent) r_postCount <= w_postInc;
        end
        default: ;
      endcase
    end
  end

  assign osType         = r_osType;
  assign sendEnable     = r_sendEnable;
  assign electricalIdle = r_electricalIdle;
  assign setTimer       = r_setTimer;
  assign enableTimer    = r_enableTimer;
  assign resetTimer     = r_resetTimer;
  assign finish         = r_finish;
  assign exitTo         = r_exitTo;

endmodule
`default_nettype wire

// File: tb/tb_master_tx_ltssm.sv
`default_nettype none
// ============================================================================
// Module      : tb_master_tx_ltssm
// Description : Directed/randomized bench for master_tx_ltssm with a
//               cycle-arithmetic reference model of finish timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_master_tx_ltssm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] substate;
  logic       osSent;
  logic       rxFinish;
  logic [3:0] rxExitTo;
  logic       timeOut;
  logic [1:0] osType;
  logic       sendEnable;
  logic       electricalIdle;
  logic [5:0] setTimer;
  logic       enableTimer;
  logic       resetTimer;
  logic       finish;
  logic [3:0] exitTo;

  master_tx_ltssm dut (
    .clk(clk), .reset(reset), .substate(substate), .osSent(osSent),
    .rxFinish(rxFinish), .rxExitTo(rxExitTo), .timeOut(timeOut),
    .osType(osType), .sendEnable(sendEnable), .electricalIdle(electricalIdle),
    .setTimer(setTimer), .enableTimer(enableTimer), .resetTimer(resetTimer),
    .finish(finish), .exitTo(exitTo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int evCyc[$];
  int evExit[$];
  int evEidle[$];
  int evSend[$];
  always @(negedge clk) begin
    if (finish === 1'b1) begin
      evCyc.push_back(cyc);
      evExit.push_back(int'(exitTo));
      evEidle.push_back(int'(electricalIdle));
      evSend.push_back(int'(sendEnable));
    end
  end

  int nChecks = 0;
  int nErr    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Spec configuration table
  function automatic int cfgOs(input int s);
    case (s)
      2, 4, 5, 6, 7: return 1;
      3, 8:          return 2;
      9:             return 3;
      default:       return 0;
    endcase
  endfunction
  function automatic int cfgMin(input int s);
    return (s == 2) ? 1024 : 0;
  endfunction
  function automatic int cfgPost(input int s);
    return (s == 3 || s == 8 || s == 9) ? 16 : 0;
  endfunction
  function automatic int cfgTimer(input int s);
    if (s == 3) return 48;
    if (s == 6) return 2;
    return 24;
  endfunction

  // Stimulus description, cycles relative to the first sendEnable cycle
  bit osArr[0:1399];
  int L, rxCyc, rxExitV, toCyc, abortCyc, newSub;

  task automatic clearStim();
    for (int i = 0; i < 1400; i++) osArr[i] = 1'b0;
    L = 0; rxCyc = -1; rxExitV = 0; toCyc = -1; abortCyc = -1; newSub = 0;
  endtask

  // Finish visible 2 cycles after the last qualifying SENDING event,
  // 1 cycle after the final POST set or a timeOut.
  task automatic predict(input int sub, output int fc, output int ex);
    int inf, q, k, cnt;
    inf = 1 << 30;
    fc = inf; ex = 0;
    if (rxCyc >= 0) begin
      if (rxExitV == 0) begin
        fc = rxCyc + 2;
      end else begin
        k = -1;
        if (cfgMin(sub) == 0) k = rxCyc;
        else begin
          cnt = 0;
          for (int t = 0; t < L; t++) begin
            if (osArr[t]) begin
              cnt++;
              if (cnt == cfgMin(sub)) begin k = t; break; end
            end
          end
        end
        if (k >= 0) begin
          q = (k > rxCyc) ? k : rxCyc;
          if (cfgPost(sub) == 0) fc = q + 2;
          else begin
            cnt = 0;
            for (int t = q + 2; t < L; t++) begin
              if (osArr[t]) begin
                cnt++;
                if (cnt == cfgPost(sub)) begin fc = t + 1; break; end
              end
            end
          end
          ex = rxExitV;
        end
      end
    end
    if (toCyc >= 0 && toCyc <= fc - 1 && (abortCyc < 0 || toCyc <= abortCyc)) begin
      fc = toCyc + 1; ex = 0;
    end else if (abortCyc >= 0 && abortCyc <= fc - 1) begin
      fc = -1;
    end
    if (fc == inf) fc = -1;
  endtask

  task automatic run(input int sub, input int expDelay);
    int waited, start, fc, ex, mark, nEv;
    bit typeOk, aborted;
    substate = 4'(sub);
    mark = evCyc.size();
    waited = 0;
    do begin step(); waited++; end while (sendEnable !== 1'b1 && waited < 6);
    check($sformatf("start_delay_s%0d", sub), waited, expDelay);
    start = cyc;
    check($sformatf("osType_s%0d", sub), osType, cfgOs(sub));
    check($sformatf("setTimer_s%0d", sub), setTimer, cfgTimer(sub));
    check($sformatf("resetTimer_s%0d", sub), resetTimer, 1);
    check($sformatf("enableTimer_s%0d", sub), enableTimer, 1);
    check($sformatf("eidle_off_s%0d", sub), electricalIdle, 0);
    typeOk = 1'b1; aborted = 1'b0;
    for (int t = 0; t < L; t++) begin
      if (sendEnable === 1'b1 && osType !== 2'(cfgOs(sub))) typeOk = 1'b0;
      if (t == 1) check($sformatf("resetTimer_width_s%0d", sub), resetTimer, 0);
      if (t == abortCyc) begin
        osSent = 1'b0; rxFinish = 1'b0; timeOut = 1'b0;
        substate = 4'(newSub);
        aborted = 1'b1;
        break;
      end
      osSent   = osArr[t];
      rxFinish = (t == rxCyc);
      rxExitTo = (t == rxCyc) ? 4'(rxExitV) : 4'($urandom);
      timeOut  = (t == toCyc);
      step();
    end
    if (!aborted) begin
      osSent = 1'b0; rxFinish = 1'b0; timeOut = 1'b0;
      repeat (4) step();
    end
    check($sformatf("osType_held_s%0d", sub), typeOk, 1);
    predict(sub, fc, ex);
    nEv = evCyc.size() - mark;
    check($sformatf("finish_count_s%0d", sub), nEv, (fc >= 0) ? 1 : 0);
    if (fc >= 0 && nEv >= 1) begin
      check($sformatf("finish_cycle_s%0d", sub), evCyc[mark] - start, fc);
      check($sformatf("exitTo_s%0d", sub), evExit[mark], ex);
      check($sformatf("finish_eidle_s%0d", sub), evEidle[mark], (ex == 0) ? 1 : 0);
      check($sformatf("finish_sendEn_s%0d", sub), evSend[mark], 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, placed, sub, prev, mark;
    bit quietOk;
    reset = 1'b1; substate = 4'd0; osSent = 1'b0; rxFinish = 1'b0;
    rxExitTo = 4'd0; timeOut = 1'b0;
    repeat (3) step();
    check("rst_osType", osType, 0);
    check("rst_sendEnable", sendEnable, 0);
    check("rst_eidle", electricalIdle, 1);
    check("rst_setTimer", setTimer, 0);
    check("rst_enableTimer", enableTimer, 0);
    check("rst_resetTimer", resetTimer, 0);
    check("rst_finish", finish, 0);
    check("rst_exitTo", exitTo, 0);
    reset = 1'b0;
    quietOk = 1'b1;
    repeat (50) begin
      step();
      if (electricalIdle !== 1'b1 || sendEnable !== 1'b0 || finish !== 1'b0) quietOk = 1'b0;
    end
    check("quiet_50", quietOk, 1);

    // pollingActive: 1024 TS1 required, RX done after set 500
    clearStim();
    t = 0; placed = 0;
    while (placed < 1024) begin
      if ($urandom_range(0, 7) != 0) begin
        osArr[t] = 1'b1; placed++;
        if (placed == 500) rxCyc = t + 1;
      end
      t++;
    end
    L = t + 4; rxExitV = 3;
    run(2, 1);

    // pollingConfiguration: RX after 5 sets, then 16 post-RX sets
    clearStim();
    for (int i = 0; i < 5; i++) osArr[i] = 1'b1;
    rxCyc = 5; rxExitV = 4;
    for (int i = 6; i < 80; i++) osArr[i] = (i >= 50) ? 1'b1 : ($urandom_range(0, 3) != 0);
    L = 80;
    run(3, 1);

    // cfgLanenumWait: timeOut and rxFinish together, FAIL wins
    clearStim();
    for (int i = 0; i < 10; i++) osArr[i] = 1'b1;
    rxCyc = 3; rxExitV = 5; toCyc = 3; L = 10;
    run(6, 1);

    // configurationComplete aborted by substate 9 after 7 post sets
    clearStim();
    rxCyc = 2; rxExitV = 9;
    for (int i = 4; i <= 10; i++) osArr[i] = 1'b1;
    abortCyc = 11; newSub = 9; L = 12;
    run(8, 1);
    clearStim();
    for (int i = 0; i < 40; i++) osArr[i] = 1'b1;
    rxCyc = 1; rxExitV = 2; L = 45;
    run(9, 2);

    // cfgLinkWidthStart: RX proposes exit 0
    clearStim();
    for (int i = 0; i < 12; i++) osArr[i] = ($urandom_range(0, 1) == 1);
    rxCyc = 3; rxExitV = 0; L = 12;
    run(4, 1);

    // Random scenarios across substates 3..9
    prev = 4;
    for (int n = 0; n < 8; n++) begin
      sub = 3 + (((prev - 3) + 1 + int'($urandom_range(0, 5))) % 7);
      clearStim();
      L = 60;
      for (int i = 0; i < L; i++) osArr[i] = (i >= 20) ? 1'b1 : ($urandom_range(0, 1) == 1);
      rxCyc   = int'($urandom_range(0, 15));
      rxExitV = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      toCyc   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 50)) : -1;
      run(sub, 1);
      prev = sub;
    end

    // Non-training substate returns TX to electrical idle
    substate = 4'd1;
    step();
    check("eidle_sub1", electricalIdle, 1);
    check("sendEn_sub1", sendEnable, 0);

    // Reset in the middle of SENDING
    substate = 4'd5;
    step(); step();
    check("mid_sendEn_before_rst", sendEnable, 1);
    mark = evCyc.size();
    reset = 1'b1;
    step();
    check("midrst_sendEnable", sendEnable, 0);
    check("midrst_eidle", electricalIdle, 1);
    check("midrst_osType", osType, 0);
    check("midrst_enableTimer", enableTimer, 0);
    check("midrst_setTimer", setTimer, 0);
    reset = 1'b0;
    step();
    check("restart_after_rst", sendEnable, 1);
    repeat (3) step();
    check("midrst_no_finish", evCyc.size() - mark, 0);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
